// File: rtl/vc_arb_mux.sv
// vc_arb_mux: merges NUM_VC first-word-fall-through VC FIFOs onto one
// registered stream using fixed-priority or round-robin arbitration.
module vc_arb_mux #(
    parameter int DATA_SIZE = 6,
    parameter int NUM_VC    = 4,
    parameter int VC_ID_W   = 2,
    parameter int RR_MODE   = 1,
    parameter int CNT_W     = 8
) (
    input  logic                          clk,
    input  logic                          reset_L,
    input  logic [NUM_VC-1:0]             fifo_empty,
    input  logic [NUM_VC*DATA_SIZE-1:0]   data_in,
    input  logic                          out_almost_full,
    output logic [NUM_VC-1:0]             pop,
    output logic [DATA_SIZE-1:0]          data_out,
    output logic                          valid_out,
    output logic [VC_ID_W-1:0]            vc_id_out,
    output logic [CNT_W-1:0]              fwd_count
);

    localparam logic [VC_ID_W-1:0] LAST_RST = VC_ID_W'(NUM_VC - 1);

    logic [NUM_VC-1:0]    w_req;
    logic                 w_gnt_vld;
    logic [VC_ID_W-1:0]   w_gnt_idx;
    logic [NUM_VC-1:0]    w_pop;
    logic [DATA_SIZE-1:0] w_sel_data;

    logic [VC_ID_W-1:0]   r_last;
    logic [DATA_SIZE-1:0] r_data;
    logic                 r_valid;
    logic [VC_ID_W-1:0]   r_vc_id;
    logic [CNT_W-1:0]     r_count;

    // k-th candidate in search order; fixed priority ignores the pointer
    function automatic logic [VC_ID_W-1:0] search_idx(
        input logic [VC_ID_W-1:0] last,
        input int                 k
    );
        int t;
        if (RR_MODE != 0) begin
            t = (int'(last) + 1 + k) % NUM_VC;
        end else begin
            t = k;
        end
        return VC_ID_W'(t);
    endfunction

    assign w_req = ~fifo_empty;

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        if (!out_almost_full) begin
            for (int k = 0; k < NUM_VC; k++) begin
                if (!w_gnt_vld && w_req[search_idx(r_last, k)]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = search_idx(r_last, k);
                end
            end
        end
    end

    always_comb begin
        w_pop = '0;
        if (reset_L && w_gnt_vld) begin
            w_pop[w_gnt_idx] = 1'b1;
        end
    end

    assign pop        = w_pop;
    assign w_sel_data = data_in[w_gnt_idx*DATA_SIZE +: DATA_SIZE];

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_last <= LAST_RST;
        end else if (RR_MODE != 0 && w_gnt_vld) begin
            r_last <= w_gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_vc_id <= '0;
            r_count <= '0;
        end else if (w_gnt_vld) begin
            r_data  <= w_sel_data;
            r_valid <= 1'b1;
            r_vc_id <= w_gnt_idx;
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end
    end

    assign data_out  = r_data;
    assign valid_out = r_valid;
    assign vc_id_out = r_vc_id;
    assign fwd_count = r_count;

endmodule

// File: doc/vc_arb_mux.md
Name: vc_arb_mux

Overview:
- Parametrised N-channel arbitrating multiplexer. It merges NUM_VC virtual-channel FIFOs, which are first-word fall-through, onto one registered output stream.
- Each cycle it issues at most one one-hot pop to a non-empty VC and registers that VC's word with a valid flag and VC id.
- Supports fixed-priority or round-robin arbitration, downstream backpressure, and a forwarded-word counter.
- Sits between the VC FIFOs and the downstream demux/output FIFO.

Parameters:
- DATA_SIZE, 6, width of one data word.
- NUM_VC, 4, number of input virtual channels (2..16).
- VC_ID_W, 2, width of VC index; must equal ceil(log2(NUM_VC)), minimum 1.
- RR_MODE, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins).
- CNT_W, 8, width of forwarded-word counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset_L  input  1  asynchronous active-low reset.
- fifo_empty  input  NUM_VC  per-VC empty flag; bit i high = VC i has no word.
- data_in  input  NUM_VC*DATA_SIZE  FWFT head words; VC i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- out_almost_full  input  1  downstream backpressure; high = no pop this cycle.
- pop  output  NUM_VC  combinational one-hot pop to VC FIFOs; all zero when no grant.
- data_out  output  DATA_SIZE  registered selected word.
- valid_out  output  1  registered; high for one cycle per forwarded word.
- vc_id_out  output  VC_ID_W  registered index of the VC that sourced data_out.
- fwd_count  output  CNT_W  registered count of forwarded words; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset_L=0, asynchronous):
  - data_out=0, valid_out=0, vc_id_out=0, fwd_count=0.
  - Round-robin pointer last_grant=NUM_VC-1, so VC0 has first priority after reset.
  - pop forced to 0 while reset_L=0.
- Request: req[i] = ~fifo_empty[i]. Stall = out_almost_full. Grant is possible only when stall=0 and req is nonzero.
- Fixed priority (RR_MODE=0): grant the lowest index i with req[i]=1. last_grant is unused and held at its reset value.
- Round-robin (RR_MODE=1):
  - Search order is last_grant+1, last_grant+2, … modulo NUM_VC; grant the first requester found.
  - On a grant, last_grant <= granted index at the next posedge.
  - With no grant, last_grant holds.
  - A single persistent requester is granted every cycle.
- pop is combinational in the same cycle as the grant, exactly one bit high. The FIFO dequeues on that posedge.
- Output register, at each posedge:
  - Grant to VC g: data_out <= data_in[g], vc_id_out <= g, valid_out <= 1, fwd_count <= fwd_count+1 (wraps from 2^CNT_W-1 to 0).
  - No grant: valid_out <= 0, data_out <= 0, vc_id_out holds, fwd_count holds.
- Latency: one cycle from pop to valid_out/data_out. Throughput is one word per cycle.
- Backpressure: out_almost_full=1 gives pop=0 in that cycle and valid_out=0 the next cycle. Arbitration state is frozen. No word is lost or duplicated.
- Simultaneous requests: only one VC is served per cycle; the others keep their words, since pop is not asserted for them.
- Empty/stall edge: a VC whose fifo_empty rises in the same cycle is not granted. Grant decisions use only current-cycle inputs.
- Reset mid-stream: outputs clear immediately and the pointer reinitialises. An in-flight pop of that cycle is not completed, because pop=0 during reset.
- No combinational path from data_in to any registered output except through the mux into the output register.

Test Plan:
- Reset: drive reset_L=0 mid-traffic -> data_out=0, valid_out=0, vc_id_out=0, fwd_count=0, pop=0 immediately. After release, the first grant with all VCs requesting goes to VC0.
- Round-robin fairness: NUM_VC=4, RR_MODE=1, all fifo_empty=0, data_in words 0x11/0x12/0x13/0x14 for VC0..3 -> pop sequence 0001,0010,0100,1000,0001; vc_id_out 0,1,2,3,0 one cycle later with matching data; valid_out continuously 1.
- Fixed priority: RR_MODE=0, VC1 and VC3 non-empty for 3 cycles -> pop=0010 each cycle, vc_id_out=1 each cycle, VC3 never granted.
- Backpressure: all VCs requesting, out_almost_full=1 for 2 cycles mid-sequence after a VC1 grant -> pop=0 and valid_out=0 for those 2 cycles; on release the next grant is VC2, with no skip or repeat.
- Sparse/idle: only VC2 non-empty for 1 cycle, then all empty -> pop=0100 once; next cycle valid_out=1, vc_id_out=2, data_out=VC2 word; following cycle valid_out=0, data_out=0, vc_id_out=2.
- Counter wrap: CNT_W=8, forward 257 words -> fwd_count reads 0xFF after word 255, 0x00 after word 256, 0x01 after word 257.
